sdram_responder: RTL and testbench
==================================

Name: sdram_responder

Overview:
- Synthesizable SDR SDRAM target model: the device end of the controller's SDRAM command interface.
- Decodes CS_n/RAS_n/CAS_n/WE_n/CKE/BA/MADDR/DQM_n and enforces the power-up sequence, bank state, mode register contents and minimum command spacing.
- Backs data with a small aliased 256x32 store, returns reads at the programmed CAS latency and honours CKE clock suspend.
- Used in simulation benches and on the FPGA self-test build to check the controller cycle by cycle.

Parameters:
T_RP, 2, minimum edges from PRECHARGE (or auto-precharge access) to ACTIVE on the same bank
T_RCD, 2, minimum edges from ACTIVE to READ/WRITE on the same bank
T_RFC, 4, minimum edges from AUTO REFRESH to any non-NOP command (next command allowed at edge REF+T_RFC+1)

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
CS_n  in  2  chip selects, one per chip, active low
RAS_n  in  1  command bit
CAS_n  in  1  command bit
WE_n  in  1  command bit
CKE  in  1  clock enable
BA  in  2  bank address
MADDR  in  13  row/column/mode address; MADDR[10] = precharge-all / auto-precharge
DQM_n  in  4  byte masks, active low enable
DQ_in  in  32  write data
DQ_out  out  32  read data
DQ_oe  out  4  per-byte read drive enable
init_done  out  1  power-up sequence and mode load complete
cas_latency  out  2  latched CL (2 or 3)
refresh_count  out  16  AUTO REFRESH commands accepted, wraps
err_pulse  out  1  one-cycle pulse per detected violation
err_code  out  4  code of first violation since reset, sticky

Behaviour:
- Reset values: DQ_out=0, DQ_oe=0, init_done=0, cas_latency=2, refresh_count=0, err_pulse=0, err_code=0.
- Reset also clears all bank-open flags, timers, the read pipeline and cke_q. Memory contents are not cleared.
- Reset mid-read drops in-flight data; DQ_oe=0 on the next cycle.
- CKE:
  - cke_q is CKE registered each edge.
  - An edge where cke_q=0 is suspended: command ignored, timers, read pipeline, DQ_out and DQ_oe all held.
  - Only non-suspended edges count toward CL and T_*.
- Command decode on non-suspended edges ({RAS_n,CAS_n,WE_n}):
  - 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 110 BURST TERMINATE, 010 PRECHARGE, 001 REFRESH, 000 LOAD MODE.
  - CS_n=11 is treated as NOP.
  - PRECHARGE, REFRESH and LOAD MODE apply to every selected chip.
  - ACTIVE, READ and WRITE with CS_n=00 raise error 9 and are ignored.
- Init FSM: WAIT_PRE -> WAIT_REF1 -> WAIT_REF2 -> WAIT_MODE -> READY.
  - WAIT_PRE advances on PRECHARGE with MADDR[10]=1.
  - Each REFRESH advances one state.
  - LOAD MODE in WAIT_MODE enters READY; init_done rises one edge later.
  - Any other non-NOP command before READY raises error 1 and the state is unchanged.
- LOAD MODE checks: MADDR[2:0]=000, MADDR[8:7]=00, MADDR[9]=1, MADDR[6:4] in {2,3}.
  - On pass, cas_latency is latched.
  - On fail, error 2 and CL unchanged.
- Bank state: 8 banks ({chip,BA}), each with an open flag, latched row, and edge counters for T_RCD/T_RP.
  - ACTIVE to an open bank: error 3.
  - ACTIVE before T_RP: error 6.
  - READ/WRITE to a closed bank: error 4.
  - READ/WRITE before T_RCD: error 5.
  - Violating commands are not executed.
- Auto-precharge:
  - READ/WRITE with MADDR[10]=1 closes the bank at the access edge and starts T_RP from that edge.
  - PRECHARGE with MADDR[10]=0 closes BA only.
- REFRESH:
  - With any selected bank open: error 8, not counted.
  - Otherwise refresh_count increments and T_RFC starts.
  - A non-NOP command inside T_RFC raises error 7.
- BURST TERMINATE: error 10.
- Store index = {chip, BA, row[1:0], MADDR[2:0]}. Aliasing is intended.
- WRITE (single access): bytes with DQM_n[i]=0 take DQ_in[8i+7:8i] at the command edge; no write latency.
- READ:
  - Word and DQM_n are captured at command edge T0.
  - At non-suspended edge T0+CL-1, DQ_out is loaded and DQ_oe = ~captured DQM_n; masked bytes read 0.
  - DQ_oe clears on the next non-suspended edge unless another read lands there. Back-to-back reads pipeline.
- Errors:
  - err_pulse fires on the violating edge.
  - err_code records only the first error; later errors pulse but do not overwrite.
  - Violations in one cycle are prioritised by lowest code.

Test Plan:
- Init: RESET then PRECHARGE(A10=1), NOP, REFRESH, 4 NOP, REFRESH, 4 NOP, LOAD MODE 0x220 -> init_done=1 one edge after LOAD MODE, cas_latency=2, refresh_count=2, err_code=0.
- Write/read: ACTIVE chip0 BA1 row 0x0003, NOP, WRITE col 5 A10=1 DQ_in=0xDEADBEEF DQM_n=0010; ACTIVE again ≥2 edges later, NOP, READ col 5 DQM_n=0 -> DQ_oe=1111 with DQ_out=0xDEAD00EF driven after edge T0+1.
- CKE hold: READ, NOP with CKE=1, then CKE=0 for 10 cycles, then CKE=1 -> DQ_out/DQ_oe held through suspend; DQ_oe clears one non-suspended edge after resume.
- Timing: READ one edge after ACTIVE -> err_pulse, err_code=5; after reset, REFRESH then ACTIVE 3 edges later -> err_code=7.
- Sequence errors: ACTIVE before init -> err_code=1; LOAD MODE 0x200 (CL=0) -> error 2; REFRESH with a bank open -> error 8, refresh_count unchanged.
- Reset mid-read: RESET asserted the edge after READ -> DQ_oe=0, init_done=0, err_code=0; memory word still readable after re-init.

Source files
------------

// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDR SDRAM target model with protocol checking and a small aliased store
module sdram_responder #(
    parameter int T_RP  = 2,
    parameter int T_RCD = 2,
    parameter int T_RFC = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  CS_n,
    input  logic        RAS_n,
    input  logic        CAS_n,
    input  logic        WE_n,
    input  logic        CKE,
    input  logic [1:0]  BA,
    input  logic [12:0] MADDR,
    input  logic [3:0]  DQM_n,
    input  logic [31:0] DQ_in,
    output logic [31:0] DQ_out,
    output logic [3:0]  DQ_oe,
    output logic        init_done,
    output logic [1:0]  cas_latency,
    output logic [15:0] refresh_count,
    output logic        err_pulse,
    output logic [3:0]  err_code
);
    typedef enum logic [2:0] {
        S_WAIT_PRE, S_WAIT_REF1, S_WAIT_REF2, S_WAIT_MODE, S_READY
    } state_t;

    localparam logic [3:0] RCD_LOAD = 4'(T_RCD - 1);
    localparam logic [3:0] RP_LOAD  = 4'(T_RP - 1);
    localparam logic [3:0] RFC_LOAD = 4'(T_RFC);

    state_t      r_state, w_state_next;
    logic        r_cke_q;
    logic [7:0]  r_open;
    logic [1:0]  r_row [8];
    logic [3:0]  r_rcd [8];
    logic [3:0]  r_rp  [8];
    logic [3:0]  r_rfc;
    logic [31:0] r_mem [256];
    logic [1:0]  r_cas;
    logic [15:0] r_refresh_count;
    logic        r_init_done;
    logic        r_err_pulse;
    logic [3:0]  r_err_code;
    logic        r_p1_v, r_p1_cl3, r_p2_v;
    logic [31:0] r_p1_d, r_p2_d, r_dq;
    logic [3:0]  r_p1_m, r_p2_m, r_oe;

    logic [2:0]  w_cmd;
    logic        w_nop, w_single, w_is_act, w_is_rd, w_is_wr, w_is_rw;
    logic        w_is_bt, w_is_pre, w_is_ref, w_is_lmr, w_mode_ok, w_init_ok, w_exec;
    logic [2:0]  w_bank;
    logic [7:0]  w_sel_banks;
    logic [7:0]  w_idx;
    logic [31:0] w_rd_word;
    logic [10:1] w_err;
    logic [3:0]  w_code;
    logic        w_land;
    logic [31:0] w_land_d;
    logic [3:0]  w_land_m;
    logic        w_unused;

    assign w_cmd       = {RAS_n, CAS_n, WE_n};
    assign w_nop       = (CS_n == 2'b11) || (w_cmd == 3'b111);
    assign w_single    = ^CS_n;
    assign w_bank      = {CS_n[0], BA};
    assign w_sel_banks = {{4{~CS_n[1]}}, {4{~CS_n[0]}}};
    assign w_is_act    = !w_nop && (w_cmd == 3'b011);
    assign w_is_rd     = !w_nop && (w_cmd == 3'b101);
    assign w_is_wr     = !w_nop && (w_cmd == 3'b100);
    assign w_is_bt     = !w_nop && (w_cmd == 3'b110);
    assign w_is_pre    = !w_nop && (w_cmd == 3'b010);
    assign w_is_ref    = !w_nop && (w_cmd == 3'b001);
    assign w_is_lmr    = !w_nop && (w_cmd == 3'b000);
    assign w_is_rw     = w_is_rd || w_is_wr;
    assign w_mode_ok   = (MADDR[2:0] == 3'b000) && (MADDR[8:7] == 2'b00) && MADDR[9]
                         && ((MADDR[6:4] == 3'd2) || (MADDR[6:4] == 3'd3));
    assign w_init_ok   = ((r_state == S_WAIT_PRE) && w_is_pre && MADDR[10])
                         || (((r_state == S_WAIT_REF1) || (r_state == S_WAIT_REF2)) && w_is_ref)
                         || ((r_state == S_WAIT_MODE) && w_is_lmr);
    assign w_idx       = {w_bank, r_row[w_bank], MADDR[2:0]};
    assign w_rd_word   = r_mem[w_idx];
    // Burst-type and high address bits carry no meaning for this single-access model
    assign w_unused    = ^{MADDR[12:11], MADDR[3]};

    always_comb begin
        w_err = '0;
        if (r_cke_q && !w_nop) begin
            w_err[1]  = (r_state != S_READY) && !w_init_ok;
            w_err[2]  = w_is_lmr && !w_mode_ok;
            w_err[3]  = w_is_act && w_single && r_open[w_bank];
            w_err[4]  = w_is_rw && w_single && !r_open[w_bank];
            w_err[5]  = w_is_rw && w_single && r_open[w_bank] && (r_rcd[w_bank] != 4'd0);
            w_err[6]  = w_is_act && w_single && (r_rp[w_bank] != 4'd0);
            w_err[7]  = r_rfc != 4'd0;
            w_err[8]  = w_is_ref && ((r_open & w_sel_banks) != 8'd0);
            w_err[9]  = (w_is_act || w_is_rw) && (CS_n == 2'b00);
            w_err[10] = w_is_bt;
        end
    end

    always_comb begin
        w_code = '0;
        for (int i = 10; i >= 1; i--) begin
            if (w_err[i]) w_code = 4'(i);
        end
    end

    assign w_exec = r_cke_q && !RESET && !w_nop && (w_err == '0);

    always_comb begin
        w_state_next = r_state;
        if (w_exec) begin
            case (r_state)
                S_WAIT_PRE:  if (w_is_pre) w_state_next = S_WAIT_REF1;
                S_WAIT_REF1: if (w_is_ref) w_state_next = S_WAIT_REF2;
                S_WAIT_REF2: if (w_is_ref) w_state_next = S_WAIT_MODE;
                S_WAIT_MODE: if (w_is_lmr) w_state_next = S_READY;
                default:     w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_WAIT_PRE;
            r_cke_q     <= 1'b0;
            r_init_done <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cke_q     <= CKE;
            r_init_done <= (r_state == S_READY);
            r_err_pulse <= w_err != '0;
            if ((w_err != '0) && (r_err_code == 4'd0)) r_err_code <= w_code;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_open          <= '0;
            r_rfc           <= '0;
            r_cas           <= 2'd2;
            r_refresh_count <= '0;
            for (int b = 0; b < 8; b++) begin
                r_row[b] <= '0;
                r_rcd[b] <= '0;
                r_rp[b]  <= '0;
            end
        end else if (r_cke_q) begin
            for (int b = 0; b < 8; b++) begin
                if (r_rcd[b] != 4'd0) r_rcd[b] <= r_rcd[b] - 4'd1;
                if (r_rp[b] != 4'd0)  r_rp[b]  <= r_rp[b] - 4'd1;
            end
            if (r_rfc != 4'd0) r_rfc <= r_rfc - 4'd1;
            if (w_exec) begin
                if (w_is_act) begin
                    r_open[w_bank] <= 1'b1;
                    r_row[w_bank]  <= MADDR[1:0];
                    r_rcd[w_bank]  <= RCD_LOAD;
                end
                if (w_is_rw && MADDR[10]) begin
                    r_open[w_bank] <= 1'b0;
                    r_rp[w_bank]   <= RP_LOAD;
                end
                if (w_is_pre) begin
                    for (int b = 0; b < 8; b++) begin
                        if (w_sel_banks[b] && (MADDR[10] || (2'(b) == BA))) begin
                            r_open[b] <= 1'b0;
                            r_rp[b]   <= RP_LOAD;
                        end
                    end
                end
                if (w_is_ref) begin
                    r_rfc           <= RFC_LOAD;
                    r_refresh_count <= r_refresh_count + 16'd1;
                end
                if (w_is_lmr) r_cas <= MADDR[5:4];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_exec && w_is_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (!DQM_n[i]) r_mem[w_idx][8*i +: 8] <= DQ_in[8*i +: 8];
            end
        end
    end

    // A CL3 read spends one extra edge in stage 2; stage 2 wins if both land together
    assign w_land   = r_p2_v || (r_p1_v && !r_p1_cl3);
    assign w_land_d = r_p2_v ? r_p2_d : r_p1_d;
    assign w_land_m = r_p2_v ? r_p2_m : r_p1_m;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_p1_v   <= 1'b0;
            r_p1_cl3 <= 1'b0;
            r_p1_d   <= '0;
            r_p1_m   <= '0;
            r_p2_v   <= 1'b0;
            r_p2_d   <= '0;
            r_p2_m   <= '0;
            r_dq     <= '0;
            r_oe     <= '0;
        end else if (r_cke_q) begin
            r_p1_v   <= w_exec && w_is_rd;
            r_p1_cl3 <= r_cas == 2'd3;
            r_p1_d   <= w_rd_word;
            r_p1_m   <= DQM_n;
            r_p2_v   <= r_p1_v && r_p1_cl3;
            r_p2_d   <= r_p1_d;
            r_p2_m   <= r_p1_m;
            if (w_land) begin
                r_dq <= w_land_d & {{8{~w_land_m[3]}}, {8{~w_land_m[2]}},
                                    {8{~w_land_m[1]}}, {8{~w_land_m[0]}}};
                r_oe <= ~w_land_m;
            end else begin
                r_oe <= '0;
            end
        end
    end

    assign DQ_out        = r_dq;
    assign DQ_oe         = r_oe;
    assign init_done     = r_init_done;
    assign cas_latency   = r_cas;
    assign refresh_count = r_refresh_count;
    assign err_pulse     = r_err_pulse;
    assign err_code      = r_err_code;
endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - directed self-checking bench for sdram_responder
module tb_sdram_responder;
    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101, C_WR = 3'b100;
    localparam logic [2:0] C_BT  = 3'b110, C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;

    logic        CLK = 1'b0;
    logic        RESET, RAS_n, CAS_n, WE_n, CKE;
    logic [1:0]  CS_n, BA;
    logic [12:0] MADDR;
    logic [3:0]  DQM_n;
    logic [31:0] DQ_in;
    logic [31:0] DQ_out;
    logic [3:0]  DQ_oe;
    logic        init_done, err_pulse;
    logic [1:0]  cas_latency;
    logic [15:0] refresh_count;
    logic [3:0]  err_code;
    int checks = 0;
    int errors = 0;

    sdram_responder dut (
        .CLK(CLK), .RESET(RESET), .CS_n(CS_n), .RAS_n(RAS_n), .CAS_n(CAS_n), .WE_n(WE_n),
        .CKE(CKE), .BA(BA), .MADDR(MADDR), .DQM_n(DQM_n), .DQ_in(DQ_in),
        .DQ_out(DQ_out), .DQ_oe(DQ_oe), .init_done(init_done), .cas_latency(cas_latency),
        .refresh_count(refresh_count), .err_pulse(err_pulse), .err_code(err_code)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] cs, input logic [2:0] c, input logic [1:0] ba,
                       input logic [12:0] a, input logic [3:0] dqm, input logic [31:0] d);
        CS_n = cs; {RAS_n, CAS_n, WE_n} = c; BA = ba; MADDR = a; DQM_n = dqm; DQ_in = d;
        @(posedge CLK);
        @(negedge CLK);
        CS_n = 2'b11; {RAS_n, CAS_n, WE_n} = C_NOP; DQM_n = 4'hF;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cmd(2'b11, C_NOP, 2'd0, 13'h0, 4'hF, 32'h0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        nop(2);
        RESET = 1'b0;
        nop(1);
    endtask

    task automatic do_init();
        cmd(2'b00, C_PRE, 2'd0, 13'h400, 4'hF, 32'h0);
        nop(1);
        cmd(2'b00, C_REF, 2'd0, 13'h000, 4'hF, 32'h0);
        nop(4);
        cmd(2'b00, C_REF, 2'd0, 13'h000, 4'hF, 32'h0);
        nop(4);
        cmd(2'b00, C_LMR, 2'd0, 13'h220, 4'hF, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; CKE = 1'b1; CS_n = 2'b11; {RAS_n, CAS_n, WE_n} = C_NOP;
        BA = 2'd0; MADDR = 13'h0; DQM_n = 4'hF; DQ_in = 32'h0;
        nop(2);
        check("rst_oe", 32'(DQ_oe), 32'h0);
        check("rst_dq", DQ_out, 32'h0);
        check("rst_init", 32'(init_done), 32'h0);
        check("rst_cl", 32'(cas_latency), 32'd2);
        check("rst_refcnt", 32'(refresh_count), 32'd0);
        check("rst_pulse", 32'(err_pulse), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        RESET = 1'b0;
        nop(1);

        cmd(2'b10, C_ACT, 2'd1, 13'h3, 4'hF, 32'h0);
        check("preinit_pulse", 32'(err_pulse), 32'd1);
        check("preinit_code", 32'(err_code), 32'd1);

        do_reset();
        do_init();
        check("lmr_init_lag", 32'(init_done), 32'd0);
        nop(1);
        check("init_done", 32'(init_done), 32'd1);
        check("init_cl", 32'(cas_latency), 32'd2);
        check("init_refcnt", 32'(refresh_count), 32'd2);
        check("init_code", 32'(err_code), 32'd0);

        cmd(2'b10, C_ACT, 2'd1, 13'h0003, 4'hF, 32'h0);
        nop(1);
        cmd(2'b10, C_WR, 2'd1, 13'h005, 4'h0, 32'h0000_0000);
        nop(1);
        cmd(2'b10, C_WR, 2'd1, 13'h405, 4'b0010, 32'hDEAD_BEEF);
        check("wr_code", 32'(err_code), 32'd0);
        nop(1);
        cmd(2'b10, C_ACT, 2'd1, 13'h0003, 4'hF, 32'h0);
        check("react_pulse", 32'(err_pulse), 32'd0);
        nop(1);
        cmd(2'b10, C_RD, 2'd1, 13'h005, 4'h0, 32'h0);
        check("rd_t0_oe", 32'(DQ_oe), 32'h0);
        nop(1);
        check("rd_oe", 32'(DQ_oe), 32'hF);
        check("rd_dq", DQ_out, 32'hDEAD_00EF);
        nop(1);
        check("rd_oe_clr", 32'(DQ_oe), 32'h0);

        cmd(2'b10, C_RD, 2'd1, 13'h005, 4'h0, 32'h0);
        cmd(2'b10, C_RD, 2'd1, 13'h005, 4'b1000, 32'h0);
        check("b2b_oe0", 32'(DQ_oe), 32'hF);
        check("b2b_dq0", DQ_out, 32'hDEAD_00EF);
        nop(1);
        check("b2b_oe1", 32'(DQ_oe), 32'h7);
        check("b2b_dq1", DQ_out, 32'h00AD_00EF);
        nop(1);
        check("b2b_oe_clr", 32'(DQ_oe), 32'h0);

        cmd(2'b10, C_RD, 2'd1, 13'h005, 4'h0, 32'h0);
        CKE = 1'b0;
        nop(1);
        check("cke_land_oe", 32'(DQ_oe), 32'hF);
        nop(4);
        check("cke_hold_oe", 32'(DQ_oe), 32'hF);
        check("cke_hold_dq", DQ_out, 32'hDEAD_00EF);
        nop(5);
        CKE = 1'b1;
        nop(1);
        check("cke_resume_oe", 32'(DQ_oe), 32'hF);
        nop(1);
        check("cke_clr_oe", 32'(DQ_oe), 32'h0);

        cmd(2'b10, C_ACT, 2'd2, 13'h0000, 4'hF, 32'h0);
        cmd(2'b10, C_RD, 2'd2, 13'h000, 4'h0, 32'h0);
        check("trcd_pulse", 32'(err_pulse), 32'd1);
        check("trcd_code", 32'(err_code), 32'd5);
        nop(1);
        check("pulse_one_cycle", 32'(err_pulse), 32'd0);
        cmd(2'b10, C_BT, 2'd0, 13'h0, 4'hF, 32'h0);
        check("bt_pulse", 32'(err_pulse), 32'd1);
        check("sticky_code", 32'(err_code), 32'd5);
        cmd(2'b10, C_REF, 2'd0, 13'h0, 4'hF, 32'h0);
        check("ref_open_pulse", 32'(err_pulse), 32'd1);
        check("ref_open_cnt", 32'(refresh_count), 32'd2);
        cmd(2'b00, C_LMR, 2'd0, 13'h200, 4'hF, 32'h0);
        check("lmr_bad_pulse", 32'(err_pulse), 32'd1);
        check("lmr_bad_cl", 32'(cas_latency), 32'd2);
        cmd(2'b00, C_LMR, 2'd0, 13'h230, 4'hF, 32'h0);
        check("lmr_cl3_pulse", 32'(err_pulse), 32'd0);
        check("lmr_cl3", 32'(cas_latency), 32'd3);

        cmd(2'b10, C_RD, 2'd1, 13'h005, 4'h0, 32'h0);
        nop(1);
        check("cl3_t1_oe", 32'(DQ_oe), 32'h0);
        nop(1);
        check("cl3_oe", 32'(DQ_oe), 32'hF);
        check("cl3_dq", DQ_out, 32'hDEAD_00EF);
        nop(1);
        check("cl3_oe_clr", 32'(DQ_oe), 32'h0);

        do_reset();
        do_init();
        nop(1);
        check("reinit_code", 32'(err_code), 32'd0);
        cmd(2'b00, C_REF, 2'd0, 13'h0, 4'hF, 32'h0);
        nop(2);
        cmd(2'b10, C_ACT, 2'd0, 13'h0, 4'hF, 32'h0);
        check("trfc_pulse", 32'(err_pulse), 32'd1);
        check("trfc_code", 32'(err_code), 32'd7);
        check("trfc_refcnt", 32'(refresh_count), 32'd3);
        nop(1);
        cmd(2'b00, C_ACT, 2'd0, 13'h0, 4'hF, 32'h0);
        check("cs00_pulse", 32'(err_pulse), 32'd1);
        cmd(2'b10, C_ACT, 2'd0, 13'h0, 4'hF, 32'h0);
        check("act_ok_pulse", 32'(err_pulse), 32'd0);
        nop(1);
        cmd(2'b10, C_PRE, 2'd0, 13'h000, 4'hF, 32'h0);
        check("pre_ok_pulse", 32'(err_pulse), 32'd0);
        cmd(2'b10, C_ACT, 2'd0, 13'h0, 4'hF, 32'h0);
        check("trp_pulse", 32'(err_pulse), 32'd1);
        cmd(2'b10, C_RD, 2'd0, 13'h0, 4'h0, 32'h0);
        check("closed_rd_pulse", 32'(err_pulse), 32'd1);
        check("closed_sticky", 32'(err_code), 32'd7);

        cmd(2'b10, C_ACT, 2'd1, 13'h0003, 4'hF, 32'h0);
        nop(1);
        cmd(2'b10, C_RD, 2'd1, 13'h005, 4'h0, 32'h0);
        RESET = 1'b1;
        nop(1);
        check("midrd_oe", 32'(DQ_oe), 32'h0);
        check("midrd_init", 32'(init_done), 32'd0);
        check("midrd_code", 32'(err_code), 32'd0);
        check("midrd_dq", DQ_out, 32'h0);
        nop(1);
        RESET = 1'b0;
        nop(1);
        do_init();
        nop(1);
        cmd(2'b10, C_ACT, 2'd1, 13'h0003, 4'hF, 32'h0);
        nop(1);
        cmd(2'b10, C_RD, 2'd1, 13'h005, 4'h0, 32'h0);
        nop(1);
        check("persist_oe", 32'(DQ_oe), 32'hF);
        check("persist_dq", DQ_out, 32'hDEAD_00EF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
